spram_fifo_ctrl: RTL and testbench
==================================

Name: spram_fifo_ctrl

Overview:
FIFO controller that sits directly upstream of the 64x8 single-port RAM (singleport_ram) and owns its data/addr/we port. It accepts a valid/ready byte stream, writes it into the RAM and reads it back in order. It presents the bytes through a one-entry output register with a valid/ready handshake. A single port means one RAM operation per cycle, so the controller arbitrates between writes and reads.

Parameters:
DW, 8, data width; matches RAM data/out width.
AW, 6, RAM address width.
DEPTH, 1<<AW (64), RAM entries used as FIFO storage.

Ports:
clk  in  1  rising-edge clock, shared with the RAM.
rst  in  1  synchronous, active-high reset.
s_valid  in  1  upstream byte valid.
s_ready  out  1  controller accepts s_data this cycle.
s_data  in  DW  upstream byte.
m_valid  out  1  output register holds a byte.
m_ready  in  1  downstream consumes the byte.
m_data  out  DW  output byte.
ram_data  out  DW  to RAM data.
ram_addr  out  AW  to RAM addr.
ram_we  out  1  to RAM we.
ram_out  in  DW  from RAM out. The RAM read is synchronous: out is registered at the edge ending the read cycle.
count  out  AW+1  total bytes held = ram_cnt + rd_pend + ov; range 0..DEPTH+1, so it is 7 bits at AW=6 (max 65).
full  out  1  ram_cnt == DEPTH.
empty  out  1  count == 0.

Behaviour:
- State registers: wr_ptr/rd_ptr (AW bits, natural wrap 63->0), ram_cnt (0..DEPTH), rd_pend, ov (output valid), m_data.
- Reset (synchronous, rst high at a rising edge): pointers=0, ram_cnt=0, rd_pend=0, ov=0, m_data=0.
- Outputs during and after reset: m_valid=0, count=0, empty=1, full=0, and s_ready=1 once rst is low.
- While rst=1, ram_we is forced to 0 combinationally. Reset mid-operation discards all contents and any in-flight read.
- Pop: pop = ov & m_ready; m_valid = ov.
- rd_issue = (ram_cnt != 0) & ~rd_pend & (~ov | pop).
- Reads have priority over writes on the single port.
- s_ready = ~rst & (ram_cnt < DEPTH) & ~rd_issue. This is a combinational path from m_ready to s_ready, and it is accepted.
- push = s_valid & s_ready.
- RAM port mux:
  - rd_issue: ram_we=0, ram_addr=rd_ptr.
  - push: ram_we=1, ram_addr=wr_ptr, ram_data=s_data.
  - idle: ram_we=0, ram_addr=rd_ptr, ram_data=s_data.
- Cycle t with rd_issue:
  - rd_ptr++, ram_cnt--, rd_pend<=1.
  - In cycle t+1, m_data<=ram_out and ov<=1 at the end of the cycle; rd_pend<=0.
  - A write in t+1 does not corrupt the capture, because ram_out is sampled before its edge.
- Push: wr_ptr++, ram_cnt++.
- push and rd_issue are mutually exclusive by construction, so ram_cnt changes by at most ±1 per cycle.
- ov update: set on rd_pend capture; cleared on pop without a capture in the same cycle. A capture and a pop cannot coincide, because rd_issue requires the stage to be free.
- Latency: byte pushed in cycle t appears with m_valid=1 in cycle t+3 when the FIFO was empty and idle.
- Sustained pop rate is 1 byte per 2 cycles. Sustained push rate is 1 per cycle while no read is due.
- Full: ram_cnt==DEPTH gives s_ready=0 and full=1; count can reach DEPTH+1 with the output register loaded.
- Empty: no read is issued while ram_cnt==0. m_valid stays 0 until a capture.
- No bypass path: every byte passes through the RAM.
- No overflow/underflow is possible; s_valid while s_ready=0 is held by upstream and not dropped.

Decomposition:
- Shared package holds the DW, AW and DEPTH constants, shared with singleport_ram and its bench.
- No sub-module: pointers, counter and arbitration stay inline.
- The RAM is instantiated alongside the controller by the integrating top, not inside it.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> m_valid=0, count=0, empty=1, full=0, s_ready=1, ram_we=0 during reset.
- Single byte: push 8'hA1 at cycle t -> ram_we=1, ram_addr=0, ram_data=A1 in t; read ram_addr=0 in t+1; m_valid=1, m_data=A1 in t+3.
- Fill with m_ready=0: offer 8'h00..8'h41 -> 65 accepted (first byte migrates to the output register), then s_ready=0, full=1, count=65.
  - Then raise m_ready -> bytes 00..40 appear in order, ending with empty=1.
- Wrap-around: stream 100 bytes (8'hB2 onward, incrementing) with m_ready=1 -> output order preserved across the 63->0 pointer wrap in both pointers.
- Port conflict: s_valid held high while output popped with ram_cnt>0 -> s_ready=0 in the rd_issue cycle, byte accepted the next cycle, and no data is lost or duplicated.
- Reset mid-stream: count=10 with a read in flight, assert rst one cycle -> next cycle count=0, m_valid=0, and no stale byte appears after release.

Source files
------------

// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared sizing for the single-port RAM FIFO and the 64x8 RAM it drives.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: not applicable.
package spram_fifo_ctrl_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_AW    = 6;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  // What the single RAM port does in a given cycle.
  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_READ  = 2'd1,
    PORT_WRITE = 2'd2
  } port_op_e;

  // Reads win the port so the output stage never starves behind a busy writer.
  function automatic port_op_e port_arb(input logic rd_issue, input logic push);
    port_op_e op;
    op = PORT_IDLE;
    if (rd_issue) begin
      op = PORT_READ;
    end else if (push) begin
      op = PORT_WRITE;
    end
    return op;
  endfunction

endpackage

// File: rtl/spram_fifo_ctrl.sv
// Byte FIFO over an external single-port RAM with a one-entry output register.
// Latency: a byte pushed into an empty, idle FIFO shows m_valid three cycles later.
// Backpressure: s_ready drops when the RAM is full or a read claims the port that cycle.
module spram_fifo_ctrl
  import spram_fifo_ctrl_pkg::*;
#(
  parameter int DW    = FIFO_DW,
  parameter int AW    = FIFO_AW,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  input  logic [DW-1:0] ram_out,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic          rd_pend;
  logic          ov;
  logic          pop;
  logic          push;
  logic          rd_issue;
  port_op_e      port_op;

  // Handshake and arbitration: a read is only launched when the output
  // register will be free to take its result, and it locks out the writer.
  always_comb begin
    pop      = ov & m_ready;
    rd_issue = (ram_cnt != '0) & ~rd_pend & (~ov | pop);
    s_ready  = ~rst & (ram_cnt < DEPTH_C) & ~rd_issue;
    push     = s_valid & s_ready;
    port_op  = port_arb(rd_issue, push);
  end

  // RAM port mux; reset gates the write enable so a reset mid-stream never
  // scribbles into storage.
  always_comb begin
    ram_we   = (port_op == PORT_WRITE) & ~rst;
    ram_addr = (port_op == PORT_WRITE) ? wr_ptr : rd_ptr;
    ram_data = s_data;
  end

  // Status: occupancy counts RAM contents, the in-flight read and the output register.
  always_comb begin
    count   = ram_cnt + (AW+1)'(rd_pend) + (AW+1)'(ov);
    full    = (ram_cnt == DEPTH_C);
    empty   = (count == '0);
    m_valid = ov;
  end

  // Pointers advance on their own operation and wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // RAM occupancy; push and rd_issue never coincide, so it moves by at most one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cnt <= '0;
    end else if (push) begin
      ram_cnt <= ram_cnt + (AW+1)'(1);
    end else if (rd_issue) begin
      ram_cnt <= ram_cnt - (AW+1)'(1);
    end
  end

  // Output stage: capture the registered RAM output the cycle after a read,
  // and release the register on a pop. A capture never lands on a pop because
  // a read is only issued into a free (or freeing) register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      ov      <= 1'b0;
      m_data  <= '0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_pend) begin
        m_data <= ram_out;
        ov     <= 1'b1;
      end else if (pop) begin
        ov <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Bench for spram_fifo_ctrl with a behavioural 64x8 single-port RAM beside it.
// Latency: not applicable.
// Backpressure: driven from the stimulus sequences below.
module tb_spram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_out;
  logic [6:0] count;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [7:0] exp_q[$];

  spram_fifo_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_out  (ram_out),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Behavioural single-port RAM: read-before-write, registered output.
  logic [7:0] mem [0:63];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_out <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted bytes are queued, delivered bytes must match in order.
  always @(negedge clk) begin
    logic [7:0] want;
    if (!rst) begin
      if (s_valid && s_ready) exp_q.push_back(s_data);
      if (m_valid && m_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=%0h required=none", m_data);
        end else begin
          want = exp_q.pop_front();
          check("sb_data", 32'(m_data), 32'(want));
        end
      end
    end
  end

  // Inputs change just after the rising edge; checks run just after the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    forever begin
      sample();
      if (s_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=stalled required=accept byte %0h", b);
        break;
      end
      step();
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    sample();
    while (!(empty && exp_q.size() == 0)) begin
      if (n >= bound) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=count %0d required=drained", name, count);
        break;
      end
      step();
      sample();
      n++;
    end
    check({name, "_empty"}, 32'(empty), 32'd1);
    check({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    step();
  endtask

  typedef struct {
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       m_ready;
    logic       e_m_valid;
    logic [7:0] e_m_data;
    logic       e_s_ready;
    logic [6:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_ram_we;
    logic [5:0] e_ram_addr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int p0;
    bit stale;

    // Reset and single-byte path, one row per cycle.
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 6'd0};
    vecs[2] = '{1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 6'd0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0, 6'd0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0, 6'd1};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0, 6'd1};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 6'd1};

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      rst = vecs[i].rst; s_valid = vecs[i].s_valid;
      s_data = vecs[i].s_data; m_ready = vecs[i].m_ready;
      sample();
      check($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_m_valid));
      if (vecs[i].e_m_valid) check($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_m_data));
      check($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_s_ready));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_ram_we));
      if (vecs[i].e_ram_we) check($sformatf("v%0d_ram_data", i), 32'(ram_data), 32'(vecs[i].s_data));
      check($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_ram_addr));
      step();
    end
    s_valid = 1'b0; m_ready = 1'b0;

    // Fill with the output stalled: 65 bytes fit, the 66th is held off.
    p0 = pops;
    for (int b = 0; b <= 8'h40; b++) send_byte(8'(b));
    s_valid = 1'b1; s_data = 8'h41;
    for (int k = 0; k < 4; k++) step();
    sample();
    check("fill_s_ready", 32'(s_ready), 32'd0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd65);
    check("fill_m_data", 32'(m_data), 32'h00);
    step();
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_drain("fill_drain", 400);
    check("fill_pops", 32'(pops - p0), 32'd65);

    // Long stream across both pointer wraps with the sink always ready.
    p0 = pops;
    for (int i = 0; i < 100; i++) send_byte(8'(8'hB2 + i));
    wait_drain("wrap_drain", 400);
    check("wrap_pops", 32'(pops - p0), 32'd100);

    // Port conflict: a pop-triggered read steals the port from a waiting writer.
    p0 = pops;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i));
    for (int k = 0; k < 3; k++) step();
    s_valid = 1'b1; s_data = 8'hC3; m_ready = 1'b1;
    sample();
    check("conflict_rd_s_ready", 32'(s_ready), 32'd0);
    check("conflict_rd_we", 32'(ram_we), 32'd0);
    step();
    sample();
    check("conflict_wr_s_ready", 32'(s_ready), 32'd1);
    check("conflict_wr_we", 32'(ram_we), 32'd1);
    step();
    s_valid = 1'b0;
    wait_drain("conflict_drain", 100);
    check("conflict_pops", 32'(pops - p0), 32'd4);

    // Reset with ten bytes held and a read in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_byte(8'(8'hD0 + i));
    step(); step();
    m_ready = 1'b1;
    sample();
    check("rstmid_pop_valid", 32'(m_valid), 32'd1);
    step();
    m_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    sample();
    check("rstmid_count_before", 32'(count), 32'd10);
    check("rstmid_we_in_rst", 32'(ram_we), 32'd0);
    check("rstmid_s_ready_in_rst", 32'(s_ready), 32'd0);
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    sample();
    check("rstmid_count", 32'(count), 32'd0);
    check("rstmid_m_valid", 32'(m_valid), 32'd0);
    check("rstmid_empty", 32'(empty), 32'd1);
    check("rstmid_s_ready", 32'(s_ready), 32'd1);
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      sample();
      if (m_valid) stale = 1'b1;
    end
    check("rstmid_no_stale", 32'(stale), 32'd0);
    step();
    p0 = pops;
    send_byte(8'hE0);
    send_byte(8'hE1);
    wait_drain("post_rst_drain", 50);
    check("post_rst_pops", 32'(pops - p0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
